// File: rtl/avalon_io_responder.sv
// Avalon-MM responder for the board switches, KEY2/KEY3 and LEDs.
// Provides a synchronized switch view, debounced keys with press counters, sticky edges and a maskable IRQ.
module avalon_io_responder #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SW_WIDTH        = 8
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                AVL_CS,
  input  logic                AVL_READ,
  input  logic                AVL_WRITE,
  input  logic [2:0]          AVL_ADDR,
  input  logic [3:0]          AVL_BYTE_EN,
  input  logic [31:0]         AVL_WRITEDATA,
  output logic [31:0]         AVL_READDATA,
  input  logic [SW_WIDTH-1:0] SW_IN,
  input  logic [1:0]          KEY_N,
  output logic [7:0]          LED_OUT,
  output logic                IRQ
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [2:0] ADDR_SW    = 3'd0;
  localparam logic [2:0] ADDR_KEY   = 3'd1;
  localparam logic [2:0] ADDR_EDGE  = 3'd2;
  localparam logic [2:0] ADDR_MASK  = 3'd3;
  localparam logic [2:0] ADDR_LED   = 3'd4;
  localparam logic [2:0] ADDR_COUNT = 3'd5;

  logic [SW_WIDTH-1:0]   sw_meta_q, sw_sync_q;
  logic [1:0]            key_meta_q, key_sync_q;
  logic [1:0]            key_lvl;
  logic [1:0]            stable_q, stable_d;
  logic [1:0][CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic [1:0]            press;
  logic [1:0]            edge_q, edge_d;
  logic [1:0]            mask_q, mask_d;
  logic [7:0]            led_q, led_d;
  logic [1:0][7:0]       count_q, count_d;
  logic [31:0]           readdata_q, readdata_d;
  logic [31:0]           rd_mux;
  logic                  wr_en, rd_en;
  logic [1:0]            edge_clr;
  logic                  unused_ok;

  assign wr_en   = AVL_CS && AVL_WRITE;
  assign rd_en   = AVL_CS && AVL_READ;
  assign key_lvl = ~key_sync_q;

  // Two-flop synchronizers; key flops reset to the released (high) pin level.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      key_meta_q <= 2'b11;
      key_sync_q <= 2'b11;
    end else begin
      sw_meta_q  <= SW_IN;
      sw_sync_q  <= sw_meta_q;
      key_meta_q <= KEY_N;
      key_sync_q <= key_meta_q;
    end
  end

  always_comb begin
    stable_d = stable_q;
    db_cnt_d = db_cnt_q;
    for (int k = 0; k < 2; k++) begin
      if (key_lvl[k] == stable_q[k]) begin
        db_cnt_d[k] = '0;
      end else if (db_cnt_q[k] == CNT_MAX) begin
        stable_d[k] = key_lvl[k];
        db_cnt_d[k] = '0;
      end else begin
        db_cnt_d[k] = db_cnt_q[k] + 1'b1;
      end
    end
  end

  assign press = stable_d & ~stable_q;

  // A press in the same cycle as a clear: edge set wins, counter clear wins.
  always_comb begin
    edge_clr = (wr_en && AVL_ADDR == ADDR_EDGE && AVL_BYTE_EN[0]) ? AVL_WRITEDATA[1:0] : 2'b00;
    edge_d   = (edge_q & ~edge_clr) | press;
    mask_d   = mask_q;
    led_d    = led_q;
    count_d  = count_q;
    if (wr_en && AVL_ADDR == ADDR_MASK && AVL_BYTE_EN[0]) mask_d = AVL_WRITEDATA[1:0];
    if (wr_en && AVL_ADDR == ADDR_LED && AVL_BYTE_EN[0])  led_d  = AVL_WRITEDATA[7:0];
    for (int k = 0; k < 2; k++) begin
      if (wr_en && AVL_ADDR == ADDR_COUNT && AVL_BYTE_EN[k]) begin
        count_d[k] = '0;
      end else if (press[k]) begin
        count_d[k] = count_q[k] + 8'd1;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (AVL_ADDR)
      ADDR_SW:    rd_mux[SW_WIDTH-1:0] = sw_sync_q;
      ADDR_KEY:   rd_mux[1:0]          = stable_q;
      ADDR_EDGE:  rd_mux[1:0]          = edge_q;
      ADDR_MASK:  rd_mux[1:0]          = mask_q;
      ADDR_LED:   rd_mux[7:0]          = led_q;
      ADDR_COUNT: rd_mux[15:0]         = {count_q[1], count_q[0]};
      default:    rd_mux               = '0;
    endcase
    readdata_d = rd_en ? rd_mux : readdata_q;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      stable_q   <= '0;
      db_cnt_q   <= '0;
      edge_q     <= '0;
      mask_q     <= '0;
      led_q      <= '0;
      count_q    <= '0;
      readdata_q <= '0;
    end else begin
      stable_q   <= stable_d;
      db_cnt_q   <= db_cnt_d;
      edge_q     <= edge_d;
      mask_q     <= mask_d;
      led_q      <= led_d;
      count_q    <= count_d;
      readdata_q <= readdata_d;
    end
  end

  assign AVL_READDATA = readdata_q;
  assign LED_OUT      = led_q;
  assign IRQ          = |(edge_q & mask_q);

  assign unused_ok = ^{AVL_WRITEDATA[31:8], AVL_BYTE_EN[3:2]};

endmodule

// File: doc/avalon_io_responder.md
Name: avalon_io_responder

Overview:
- Avalon-MM responder peripheral for the Nios II bus. Replaces the separate switch, key and LED PIOs with a single register-mapped block.
- Synchronizes the 8 board switches.
- Debounces KEY2/KEY3, which are active-low on the board, and counts presses.
- Latches press edges into a sticky edge register that can raise a maskable interrupt.
- Holds the LED output register.
- Sits between the SoC bus fabric and the board I/O pins.

Parameters:
DEBOUNCE_CYCLES, 500000, cycles a synchronized key level must stay stable before it is accepted (10 ms at 50 MHz); legal range ≥2.
SW_WIDTH, 8, number of switch inputs.

Ports:
Clk  input  1  system clock (single clock domain)
Reset  input  1  asynchronous, active-high reset
AVL_CS  input  1  chip select
AVL_READ  input  1  read strobe, qualified by AVL_CS
AVL_WRITE  input  1  write strobe, qualified by AVL_CS
AVL_ADDR  input  3  word address
AVL_BYTE_EN  input  4  write byte enables
AVL_WRITEDATA  input  32  write data
AVL_READDATA  output  32  read data, registered
SW_IN  input  SW_WIDTH  raw switch pins
KEY_N  input  2  raw key pins, active-low; bit0=KEY2, bit1=KEY3
LED_OUT  output  8  LED drive
IRQ  output  1  level interrupt to the CPU

Behaviour:
- Reset (async, active-high) values:
  - AVL_READDATA=0, LED_OUT=0, IRQ=0.
  - Edge, mask and count registers = 0.
  - Key synchronizer flops = 1 (released).
  - Debounced key state = 0; debounce counters = 0.
  - Switch synchronizer flops = 0.
- Input synchronization:
  - SW_IN and KEY_N each pass through a 2-flop synchronizer.
  - Switch value is readable 2 cycles after the pin changes.
- Key inversion: the synchronized key is inverted, so pressed=1.
- Debounce, per key:
  - If the synchronized level equals the stable level, the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter = DEBOUNCE_CYCLES-1 and the level still differs, the stable level takes the new value and the counter clears.
  - Any bounce back to the stable level restarts the count from 0.
- Press event: stable level 0→1 in a cycle.
  - Sets edge[k].
  - Increments count[k], an 8-bit counter that wraps 255→0.
- Release (1→0) has no effect on edge or count.
- Register map (word address, bits beyond those listed read 0):
  - 0 SW (RO): [SW_WIDTH-1:0] synchronized switches.
  - 1 KEY (RO): [1:0] debounced pressed levels.
  - 2 EDGE (R/W1C): [1:0] sticky press events. Writing 1 with BYTE_EN[0] clears the bit.
  - 3 MASK (RW): [1:0] interrupt enables.
  - 4 LED (RW): [7:0]. LED_OUT reflects this register directly.
  - 5 COUNT (RW-clear): [7:0] KEY2 presses, [15:8] KEY3 presses. A write with BYTE_EN[0] clears [7:0] and with BYTE_EN[1] clears [15:8], regardless of data.
  - 6, 7: read 0, writes ignored.
- Byte enables: a register field updates only when its byte lane is enabled. Disabled lanes keep their old value.
- Bus timing:
  - Write takes effect at the clock edge where AVL_CS&&AVL_WRITE is sampled.
  - Read: the AVL_READDATA register is loaded at the edge where AVL_CS&&AVL_READ is sampled; fixed read latency 1.
  - When no read is active, AVL_READDATA holds its last value.
  - Read and write both asserted: the write is performed and the read returns the pre-write value.
  - No wait states; every access completes in one cycle.
- Simultaneous events:
  - A press event and a W1C clear of the same EDGE bit in one cycle: the set wins and the bit stays 1.
  - A press event and a COUNT clear of the same lane: the counter becomes 0; that press is dropped.
  - Reading EDGE does not clear it.
- IRQ = |(EDGE & MASK), computed from registered values only, so it is glitch-free.
  - IRQ rises in the cycle after the edge bit sets, provided the mask is already 1.
  - Setting the mask with an edge already pending asserts IRQ the cycle after the write.
- Reset mid-operation: everything returns to reset values immediately. A key held through reset is re-detected as a press after it passes the synchronizer and DEBOUNCE_CYCLES.

Test Plan:
- DEBOUNCE_CYCLES=4 for all tests.
- Reset, then read addresses 0–7 → SW equals the pins after the synchronizer delay; every other address reads 0; LED_OUT=0; IRQ=0.
- Hold KEY_N[0]=0 for 10 cycles → KEY reads 0x1; EDGE reads 0x1; COUNT reads 0x0001. Glitch KEY_N[1] low for 3 cycles → no change to KEY3 state.
- Write MASK=0x1 with KEY2 edge pending → IRQ=1 on the next cycle. Write EDGE=0x1 → IRQ=0 on the next cycle. Clear coinciding with a new press edge → EDGE stays 0x1 and IRQ stays 1.
- Write LED=0xA5 with BYTE_EN=4'b0001 → LED_OUT=0xA5. Write 0xFF with BYTE_EN=4'b0010 → LED_OUT stays 0xA5.
- Generate 256 KEY3 presses → COUNT[15:8] wraps to 0x00. Write COUNT with BYTE_EN=4'b0010 after 3 further presses → [15:8]=0, [7:0] unchanged.
- Assert Reset while KEY2 is held and EDGE=0x3 → all registers are 0 immediately. After release of Reset with the key still held, KEY2 is re-debounced and EDGE becomes 0x1 after 2+4 cycles.
